uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, one or two stop bits.
// Every output is a flop, so each output change shows up one cycle after the edge that causes it.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic       o_Tx_Ready
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_byte;
    logic               r_serial;
    logic               r_active;
    logic               r_done;
    logic               r_ready;

    state_e             w_state_nxt;
    logic [CNT_W-1:0]   w_clk_cnt_nxt;
    logic [2:0]         w_bit_idx_nxt;
    logic               w_stop_idx_nxt;
    logic [7:0]         w_byte_nxt;
    logic               w_serial_nxt;
    logic               w_active_nxt;
    logic               w_done_nxt;
    logic               w_ready_nxt;
    logic               w_bit_end;

    assign w_bit_end = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state    <= StIdle;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_byte     <= '0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_byte     <= w_byte_nxt;
            r_serial   <= w_serial_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = r_clk_cnt + CNT_W'(1);
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_byte_nxt     = r_byte;
        unique case (r_state)
            StIdle: begin
                w_clk_cnt_nxt  = '0;
                w_bit_idx_nxt  = '0;
                w_stop_idx_nxt = 1'b0;
                if (i_Tx_DV) begin
                    w_state_nxt = StStart;
                    w_byte_nxt  = i_Tx_Byte;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = StData;
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = StStop;
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        w_stop_idx_nxt = 1'b0;
                        w_state_nxt    = StIdle;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_clk_cnt_nxt = '0;
                w_state_nxt   = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        w_serial_nxt = 1'b1;
        w_active_nxt = 1'b1;
        w_ready_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (w_state_nxt)
            StIdle: begin
                w_active_nxt = 1'b0;
                w_ready_nxt  = 1'b1;
                w_done_nxt   = (r_state == StStop);
            end
            StStart:  w_serial_nxt = 1'b0;
            StData:   w_serial_nxt = w_byte_nxt[w_bit_idx_nxt];
            StParity: w_serial_nxt = (^r_byte) ^ (PARITY_ODD != 0);
            StStop:   w_serial_nxt = 1'b1;
            default: begin
                w_active_nxt = 1'b0;
                w_ready_nxt  = 1'b1;
            end
        endcase
    end

    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;
    assign o_Tx_Ready  = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants run side by side against a frame-position model,
// plus directed literal checks of the waveforms.
module tb_uart_tx;

    logic            clk;
    logic            rst_n;
    logic [3:0]      dv;
    logic [3:0][7:0] txb;
    logic [3:0]      ser;
    logic [3:0]      act;
    logic [3:0]      done;
    logic [3:0]      rdy;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 0;

    // Model: position inside the frame (-1 idle, 0..L-1 on the line, L the done cycle).
    int         phase [4] = '{-1, -1, -1, -1};
    logic [7:0] lat   [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx u_dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(txb[0]),
        .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]), .o_Tx_Ready(rdy[0])
    );
    uart_tx #(.CLKS_PER_BIT(87), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(txb[1]),
        .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]), .o_Tx_Ready(rdy[1])
    );
    uart_tx #(.CLKS_PER_BIT(87), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(txb[2]),
        .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]), .o_Tx_Ready(rdy[2])
    );
    uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut3 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(txb[3]),
        .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3]), .o_Tx_Ready(rdy[3])
    );

    function automatic int cpb(int i);
        return (i == 3) ? 2 : 87;
    endfunction
    function automatic int pen(int i);
        return (i == 1 || i == 3) ? 1 : 0;
    endfunction
    function automatic int podd(int i);
        return (i == 3) ? 1 : 0;
    endfunction
    function automatic int nstop(int i);
        return (i >= 2) ? 2 : 1;
    endfunction
    function automatic int flen(int i);
        return (9 + pen(i) + nstop(i)) * cpb(i);
    endfunction

    function automatic logic exp_ser(int i);
        int b;
        if (phase[i] < 0 || phase[i] >= flen(i)) return 1'b1;
        b = phase[i] / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return lat[i][b-1];
        if (b == 9 && pen(i) != 0) return (^lat[i]) ^ (podd(i) != 0);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, a, e, $time);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) phase[i] <= -1;
            else if (phase[i] >= 0 && phase[i] < flen(i)) phase[i] <= phase[i] + 1;
            else if (dv[i]) begin
                phase[i] <= 0;
                lat[i]   <= txb[i];
            end else phase[i] <= -1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                logic on_line;
                on_line = (phase[i] >= 0 && phase[i] < flen(i));
                chk($sformatf("serial[%0d]", i), 32'(ser[i]), 32'(exp_ser(i)));
                chk($sformatf("active[%0d]", i), 32'(act[i]), 32'(on_line));
                chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(!on_line));
                chk($sformatf("done[%0d]", i), 32'(done[i]), 32'(phase[i] == flen(i)));
            end
        end
    end

    // Behavioural receiver on instance 0, sampling mid-bit.
    task automatic rx0(output logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        b  = '0;
        while (ser[0] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) return;
        repeat (43) @(negedge clk);
        if (ser[0] !== 1'b0) return;
        for (int j = 0; j < 8; j++) begin
            repeat (87) @(negedge clk);
            b[j] = ser[0];
        end
        repeat (87) @(negedge clk);
        ok = (ser[0] === 1'b1);
    endtask

    initial begin
        logic [1000:0] rec0, rec1, rec3;
        logic [9:0]    pat;
        logic [7:0]    rxb;
        bit            rxok;
        int            d0, d1, d3, n, cnt;

        rst_n = 1'b0;
        dv    = 4'hF;
        txb   = {4{8'hAB}};
        repeat (3) @(negedge clk);
        mon_en = 1;
        chk("reset_serial", 32'(ser[0]), 1);
        chk("reset_active", 32'(act[0]), 0);
        chk("reset_done", 32'(done[0]), 0);
        chk("reset_ready", 32'(rdy[0]), 1);

        // 0xAB on instances 0, 1, 3, accepted on the first edge out of reset.
        rst_n = 1'b1;
        dv    = 4'b1011;
        @(negedge clk);
        dv = 4'b0000;
        d0 = -1; d1 = -1; d3 = -1;
        for (int k = 0; k <= 1000; k++) begin
            rec0[k] = ser[0];
            rec1[k] = ser[1];
            rec3[k] = ser[3];
            if (done[0] && d0 < 0) d0 = k;
            if (done[1] && d1 < 0) d1 = k;
            if (done[3] && d3 < 0) d3 = k;
            @(negedge clk);
        end
        pat = 10'b11_0101_0110;
        for (int b = 0; b < 10; b++)
            chk($sformatf("ab_bit%0d", b), 32'(rec0[b*87+43]), 32'(pat[b]));
        chk("ab_done_at", d0, 870);
        chk("even_parity_bit", 32'(rec1[9*87+43]), 1);
        chk("even_parity_done_at", d1, 957);
        chk("odd_parity_bit", 32'(rec3[9*2+1]), 0);
        chk("odd_parity_done_at", d3, 24);

        // Back-to-back frames on the two-stop-bit instance.
        txb[2] = 8'h3F;
        dv[2]  = 1'b1;
        @(negedge clk);
        dv[2] = 1'b0;
        n = 0;
        while (!done[2] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done1_at", n, 957);
        txb[2] = 8'h55;
        dv[2]  = 1'b1;
        @(negedge clk);
        dv[2] = 1'b0;
        chk("b2b_second_start", 32'(ser[2]), 0);
        cnt = 0;
        for (int k = 0; k < 1100; k++) begin
            if (done[2]) cnt++;
            @(negedge clk);
        end
        chk("b2b_second_done_count", cnt, 1);

        // DV and byte change mid-frame are ignored.
        txb[0] = 8'hFF;
        dv[0]  = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (100) @(negedge clk);
        txb[0] = 8'h00;
        dv[0]  = 1'b1;
        cnt = 0;
        for (int k = 0; k < 1500; k++) begin
            if (k == 600) dv[0] = 1'b0;
            if (done[0]) cnt++;
            @(negedge clk);
        end
        chk("ignored_dv_done_count", cnt, 1);

        // Reset during data bit 3, then a clean frame into the receiver.
        txb[0] = 8'h5A;
        dv[0]  = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (4 * 87 + 20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_serial", 32'(ser[0]), 1);
        chk("abort_active", 32'(act[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            if (done[0]) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", cnt, 0);
        txb[0] = 8'h3F;
        dv[0]  = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        rx0(rxb, rxok);
        chk("rx_byte", 32'(rxb), 32'h3F);
        chk("rx_stop_ok", 32'(rxok), 1);

        // Random traffic, occasional resets and long DV holds.
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ((c / 2000) % 2 == 1 && i == 3) dv[i] = 1'b1;
                else dv[i] = ($urandom_range(0, (i == 3) ? 3 : 9) == 0);
                txb[i] = 8'($urandom);
            end
            rst_n = ($urandom_range(0, 2999) != 0);
        end
        @(negedge clk);
        dv    = 4'b0000;
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
